// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - instruction/data memory responder with boot loader
// The loader fills imem from a valid/ready stream while the CPU is held in reset.
module cpu_mem_responder #(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [18:0]                 PC,
  output logic [18:0]                 Instr,
  input  logic [18:0]                 Mem_wr_addr,
  input  logic [18:0]                 Mem_wr_data,
  input  logic                        MemWrite,
  output logic [18:0]                 ReadData,
  input  logic                        load_valid,
  input  logic [18:0]                 load_data,
  input  logic                        load_last,
  output logic                        load_ready,
  output logic                        cpu_reset,
  output logic                        load_done,
  output logic [$clog2(IMEM_DEPTH):0] load_count
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IAW:0]   count_q, count_d;
  logic [18:0]    imem [IMEM_DEPTH];
  logic [18:0]    dmem [DMEM_DEPTH];

  logic           load_fire;
  logic [IAW-1:0] ptr;
  logic           mem_full;
  logic           imem_hit;
  logic           dmem_hit;

  // The write pointer is the low bits of the accepted-word count.
  assign ptr       = count_q[IAW-1:0];
  assign mem_full  = (ptr == IAW'(IMEM_DEPTH - 1));
  assign load_fire = (state_q == S_LOAD) && load_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOAD;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_LOAD: begin
        if (load_fire) begin
          count_d = count_q + 1'b1;
          if (load_last || mem_full) state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_RUN;
      S_RUN:     state_d = S_RUN;
      default:   state_d = S_LOAD;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    cpu_reset  = 1'b1;
    load_done  = 1'b0;
    case (state_q)
      S_LOAD:    load_ready = 1'b1;
      S_RELEASE: cpu_reset  = 1'b1;
      S_RUN: begin
        cpu_reset = 1'b0;
        load_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign load_count = count_q;

  // Memories carry no reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (reset && load_fire) imem[ptr] <= load_data;
  end

  assign dmem_hit = (Mem_wr_addr < 19'(DMEM_DEPTH));

  always_ff @(posedge clk) begin
    if (reset && MemWrite && (state_q == S_RUN) && dmem_hit)
      dmem[Mem_wr_addr[DAW-1:0]] <= Mem_wr_data;
  end

  assign imem_hit = (state_q == S_RUN) && (PC < 19'(IMEM_DEPTH));
  assign Instr    = imem_hit ? imem[PC[IAW-1:0]] : 19'h0;
  assign ReadData = dmem_hit ? dmem[Mem_wr_addr[DAW-1:0]] : 19'h0;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - randomized bench with behavioural memory/loader model
module tb_cpu_mem_responder;
  localparam int ID = 8;
  localparam int DD = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] PC, Instr, Mem_wr_addr, Mem_wr_data, ReadData, load_data;
  logic        MemWrite, load_valid, load_last, load_ready, cpu_reset, load_done;
  logic [3:0]  load_count;

  always #5 clk = ~clk;

  cpu_mem_responder #(.IMEM_DEPTH(ID), .DMEM_DEPTH(DD)) dut (
    .clk(clk), .reset(reset), .PC(PC), .Instr(Instr),
    .Mem_wr_addr(Mem_wr_addr), .Mem_wr_data(Mem_wr_data), .MemWrite(MemWrite),
    .ReadData(ReadData), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .cpu_reset(cpu_reset),
    .load_done(load_done), .load_count(load_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Model: words accepted, and edges since the final word (-1 while loading).
  logic [18:0] m_imem [ID];
  bit          m_ik   [ID];
  logic [18:0] m_dmem [DD];
  bit          m_dk   [DD];
  int          m_cnt = 0;
  int          m_after = -1;

  always @(negedge reset) begin
    m_cnt   = 0;
    m_after = -1;
  end

  always @(posedge clk) begin
    if (reset) begin
      if (m_after >= 1) begin
        if (MemWrite && Mem_wr_addr < DD) begin
          m_dmem[int'(Mem_wr_addr)] = Mem_wr_data;
          m_dk[int'(Mem_wr_addr)]   = 1'b1;
        end
      end else if (m_after == 0) begin
        m_after = 1;
      end else if (load_valid) begin
        m_imem[m_cnt] = load_data;
        m_ik[m_cnt]   = 1'b1;
        m_cnt++;
        if (load_last || m_cnt == ID) m_after = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("load_ready", load_ready, (m_after < 0) ? 1 : 0);
      chk("cpu_reset", cpu_reset, (m_after < 1) ? 1 : 0);
      chk("load_done", load_done, (m_after >= 1) ? 1 : 0);
      chk("load_count", load_count, m_cnt);
      if (m_after < 1 || PC >= ID) chk("instr_zero", Instr, 0);
      else if (m_ik[int'(PC)]) chk("instr", Instr, m_imem[int'(PC)]);
      if (Mem_wr_addr >= DD) chk("rdata_zero", ReadData, 0);
      else if (m_dk[int'(Mem_wr_addr)]) chk("rdata", ReadData, m_dmem[int'(Mem_wr_addr)]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_reset"}, cpu_reset, 1);
    chk({tag, "_load_ready"}, load_ready, 1);
    chk({tag, "_load_done"}, load_done, 0);
    chk({tag, "_load_count"}, load_count, 0);
    chk({tag, "_instr"}, Instr, 0);
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      PC          = 19'($urandom_range(0, ID + 2));
      Mem_wr_addr = ($urandom_range(0, 9) == 0) ? 19'h7FFFF : 19'($urandom_range(0, DD + 3));
      Mem_wr_data = 19'($urandom);
      MemWrite    = 1'($urandom_range(0, 1));
      cyc();
    end
    MemWrite = 1'b0;
  endtask

  logic [18:0] w [4];
  logic [18:0] first_fill;

  initial begin
    w[0] = 19'h00013; w[1] = 19'h7FFFF; w[2] = 19'h12345; w[3] = 19'h40001;
    reset = 1'b0; PC = '0; Mem_wr_addr = '0; Mem_wr_data = '0; MemWrite = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    repeat (3) cyc();
    chk_reset_vals("por");
    reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = w[i]; load_last = (i == 3);
      cyc();
    end
    load_valid = 1'b0; load_last = 1'b0;
    #1;
    chk("lit_count4", load_count, 4);
    chk("lit_release_cpu_reset", cpu_reset, 1);
    chk("lit_release_ready", load_ready, 0);
    cyc();
    chk("lit_run_cpu_reset", cpu_reset, 0);
    chk("lit_run_done", load_done, 1);
    for (int i = 0; i < 4; i++) begin
      PC = 19'(i);
      #1 chk("lit_instr", Instr, w[i]);
      cyc();
    end

    Mem_wr_addr = 19'd3; Mem_wr_data = 19'h5A5A5; MemWrite = 1'b1;
    cyc();
    MemWrite = 1'b0;
    #1 chk("lit_store3", ReadData, 19'h5A5A5);
    Mem_wr_addr = 19'h7FFFF; Mem_wr_data = 19'h2AAAA; MemWrite = 1'b1;
    cyc();
    MemWrite = 1'b0;
    #1 chk("lit_oor_read", ReadData, 0);
    PC = 19'(ID);
    #1 chk("lit_pc_oor", Instr, 0);

    random_run(150);
    Mem_wr_addr = 19'd2; Mem_wr_data = 19'h11111; MemWrite = 1'b1;
    cyc();
    MemWrite = 1'b0;

    reset = 1'b0;
    #1 chk_reset_vals("midrun");
    cyc();
    reset = 1'b1;

    // Gapped load with a stray load_last and blocked stores to dmem[2].
    for (int i = 0; i < 5; i++) begin
      load_valid  = (i % 2 == 0);
      load_data   = 19'($urandom);
      load_last   = (i == 1) || (i == 4);
      MemWrite    = 1'b1; Mem_wr_addr = 19'd2; Mem_wr_data = 19'h33333;
      cyc();
    end
    load_valid = 1'b0; load_last = 1'b0; MemWrite = 1'b0;
    #1 chk("lit_gap_count", load_count, 3);
    cyc();
    Mem_wr_addr = 19'd2;
    #1 chk("lit_dmem2_kept", ReadData, 19'h11111);
    random_run(60);

    reset = 1'b0;
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = 19'($urandom); load_last = 1'b0;
      cyc();
    end
    reset = 1'b0;
    #1 chk_reset_vals("midload");
    cyc();
    reset = 1'b1;

    for (int i = 0; i < ID; i++) begin
      load_valid = 1'b1; load_data = 19'($urandom); load_last = 1'b0;
      if (i == 0) first_fill = load_data;
      cyc();
    end
    load_data = 19'h7ABCD;
    #1;
    chk("lit_full_count", load_count, ID);
    chk("lit_full_ready", load_ready, 0);
    cyc();
    chk("lit_ninth_rejected", load_count, ID);
    load_valid = 1'b0;
    PC = 19'd0;
    #1 chk("lit_fill_instr0", Instr, first_fill);
    random_run(80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
